// File: rtl/pkg_mapa_memoria.sv
// Memory map, one-hot read-data selects and FSM state type shared by the
// bus decoder and the read-data multiplexer.
package pkg_mapa_memoria;

    localparam logic [31:0] RAM_BASE    = 32'h0000_1000;
    localparam logic [31:0] RAM_MASK    = 32'hFFFF_F000;
    localparam logic [31:0] SW_ADDR     = 32'h0000_2000;
    localparam logic [31:0] LED_ADDR    = 32'h0000_2004;
    localparam logic [31:0] SEG_ADDR    = 32'h0000_2008;
    localparam logic [31:0] UART_A_BASE = 32'h0000_2010;
    localparam logic [31:0] UART_B_BASE = 32'h0000_2020;
    localparam logic [31:0] UART_C_BASE = 32'h0000_2030;
    localparam logic [31:0] UART_MASK   = 32'hFFFF_FFF0;

    localparam logic [6:0] SEL_NINGUNO = 7'b000_0000;
    localparam logic [6:0] SEL_RAM     = 7'b000_0001;
    localparam logic [6:0] SEL_SW      = 7'b000_0010;
    localparam logic [6:0] SEL_LED     = 7'b000_0100;
    localparam logic [6:0] SEL_7SEG    = 7'b000_1000;
    localparam logic [6:0] SEL_UART_A  = 7'b001_0000;
    localparam logic [6:0] SEL_UART_B  = 7'b010_0000;
    localparam logic [6:0] SEL_UART_C  = 7'b100_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    function automatic logic es_uart(input logic [6:0] sel);
        return |sel[6:4];
    endfunction

endpackage

// File: rtl/decodificador_direccion.sv
// Combinational address decoder: CPU byte address to one-hot target plus a
// valid flag (valid only for mapped, word-aligned addresses).
module decodificador_direccion
    import pkg_mapa_memoria::*;
(
    input  logic [31:0] addr_i,
    output logic [6:0]  destino_o,
    output logic        valido_o
);

    logic [6:0] destino_mapa;

    always_comb begin
        destino_mapa = SEL_NINGUNO;
        if ((addr_i & RAM_MASK) == RAM_BASE)           destino_mapa = SEL_RAM;
        else if (addr_i == SW_ADDR)                    destino_mapa = SEL_SW;
        else if (addr_i == LED_ADDR)                   destino_mapa = SEL_LED;
        else if (addr_i == SEG_ADDR)                   destino_mapa = SEL_7SEG;
        else if ((addr_i & UART_MASK) == UART_A_BASE)  destino_mapa = SEL_UART_A;
        else if ((addr_i & UART_MASK) == UART_B_BASE)  destino_mapa = SEL_UART_B;
        else if ((addr_i & UART_MASK) == UART_C_BASE)  destino_mapa = SEL_UART_C;
    end

    // Misaligned addresses are unmapped even inside a valid window.
    always_comb begin
        valido_o  = (addr_i[1:0] == 2'b00) && (destino_mapa != SEL_NINGUNO);
        destino_o = valido_o ? destino_mapa : SEL_NINGUNO;
    end

endmodule

// File: rtl/decodificador_bus.sv
// CPU bus decoder: single-cycle access to RAM/switches/LED/7-seg, stalled
// handshake with three UARTs bounded by a timeout, registered read select.
module decodificador_bus
    import pkg_mapa_memoria::*;
#(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [2:0]  uart_ready_i,
    output logic        we_ram_o,
    output logic        we_led_o,
    output logic        we_7seg_o,
    output logic [2:0]  req_uart_o,
    output logic [6:0]  sel_dispositivo_o,
    output logic        stall_o,
    output logic        error_bus_o,
    output estado_t     estado_o
);

    // Handshake: the CPU presents we_i/re_i with addr_i and must hold them
    // while stall_o=1; the access completes in the first cycle with stall_o=0.

    logic [6:0] destino;
    logic       valido;
    logic       peticion;
    logic       acceso_ok;
    logic       listo;
    logic       fin_tiempo;

    estado_t    estado;
    logic [7:0] contador;
    logic [6:0] destino_q;
    logic       escritura_q;

    decodificador_direccion u_dec (
        .addr_i    (addr_i),
        .destino_o (destino),
        .valido_o  (valido)
    );

    assign peticion   = we_i | re_i;
    assign acceso_ok  = peticion && !(we_i && re_i) && valido;
    // Only the ready bit of the latched UART counts.
    assign listo      = |(uart_ready_i & destino_q[6:4]);
    assign fin_tiempo = (contador == 8'(TIMEOUT_CICLOS - 1));
    assign estado_o   = estado;

    // Strobes and stall are gated by reset so they drop immediately.
    always_comb begin
        we_ram_o   = 1'b0;
        we_led_o   = 1'b0;
        we_7seg_o  = 1'b0;
        req_uart_o = 3'b000;
        stall_o    = 1'b0;
        if (rst_n_i) begin
            case (estado)
                IDLE: begin
                    if (acceso_ok) begin
                        if (es_uart(destino)) begin
                            req_uart_o = destino[6:4];
                            stall_o    = 1'b1;
                        end else if (we_i) begin
                            we_ram_o  = destino[0];
                            we_led_o  = destino[2];
                            we_7seg_o = destino[3];
                        end
                    end
                end
                ESPERA: stall_o = !listo && !fin_tiempo;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            estado            <= IDLE;
            contador          <= 8'd0;
            destino_q         <= SEL_NINGUNO;
            escritura_q       <= 1'b0;
            sel_dispositivo_o <= SEL_NINGUNO;
            error_bus_o       <= 1'b0;
        end else begin
            sel_dispositivo_o <= SEL_NINGUNO;
            error_bus_o       <= 1'b0;
            case (estado)
                IDLE: begin
                    if (peticion) begin
                        if (!acceso_ok) begin
                            error_bus_o <= 1'b1;
                        end else if (es_uart(destino)) begin
                            destino_q   <= destino;
                            escritura_q <= we_i;
                            contador    <= 8'd0;
                            estado      <= ESPERA;
                        end else if (re_i) begin
                            sel_dispositivo_o <= destino;
                        end
                    end
                end
                ESPERA: begin
                    // Ready takes priority over a simultaneous timeout.
                    if (listo) begin
                        sel_dispositivo_o <= escritura_q ? SEL_NINGUNO : destino_q;
                        estado            <= IDLE;
                    end else if (fin_tiempo) begin
                        error_bus_o <= 1'b1;
                        estado      <= IDLE;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decodificador_bus.sv
// Randomized bench for decodificador_bus against a transaction-level model
// of the memory map, UART wait and timeout behaviour.
module tb_decodificador_bus;
    import pkg_mapa_memoria::*;

    localparam int T = 16;

    logic        clk_i;
    logic        rst_n_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic        re_i;
    logic [2:0]  uart_ready_i;
    logic        we_ram_o;
    logic        we_led_o;
    logic        we_7seg_o;
    logic [2:0]  req_uart_o;
    logic [6:0]  sel_dispositivo_o;
    logic        stall_o;
    logic        error_bus_o;
    estado_t     estado_dbg;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    decodificador_bus #(.TIMEOUT_CICLOS(T)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .addr_i            (addr_i),
        .we_i              (we_i),
        .re_i              (re_i),
        .uart_ready_i      (uart_ready_i),
        .we_ram_o          (we_ram_o),
        .we_led_o          (we_led_o),
        .we_7seg_o         (we_7seg_o),
        .req_uart_o        (req_uart_o),
        .sel_dispositivo_o (sel_dispositivo_o),
        .stall_o           (stall_o),
        .error_bus_o       (error_bus_o),
        .estado_o          (estado_dbg)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 no request, 1 fast target, 2 UART, 3 failed access
    task automatic ref_decode(input logic w, input logic r, input logic [31:0] a,
                              output int kind, output logic [6:0] oh);
        oh = 7'd0;
        if (!w && !r) begin
            kind = 0;
            return;
        end
        if (a >= 32'h1000 && a <= 32'h1FFF) oh = 7'd1;
        else if (a == 32'h2000) oh = 7'd2;
        else if (a == 32'h2004) oh = 7'd4;
        else if (a == 32'h2008) oh = 7'd8;
        else if (a >= 32'h2010 && a <= 32'h201F) oh = 7'd16;
        else if (a >= 32'h2020 && a <= 32'h202F) oh = 7'd32;
        else if (a >= 32'h2030 && a <= 32'h203F) oh = 7'd64;
        if ((w && r) || (a % 4 != 0) || oh == 7'd0) begin
            kind = 3;
            oh   = 7'd0;
        end else if (oh >= 7'd16) begin
            kind = 2;
        end else begin
            kind = 1;
        end
    endtask

    // One sampled cycle: combinational outputs now, registered outputs
    // against what the previous cycle predicted.
    task automatic tick(input logic [2:0] e_req, input logic e_stall,
                        input logic [2:0] e_we, input logic [7:0] e_reg_next);
        logic [7:0] e;
        check("req_uart", req_uart_o, e_req);
        check("stall", stall_o, e_stall);
        check("we_7seg_led_ram", {we_7seg_o, we_led_o, we_ram_o}, e_we);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check("sel", sel_dispositivo_o, e[6:0]);
        check("error_bus", error_bus_o, e[7]);
        exp_q.push_back(e_reg_next);
    endtask

    // d: cycles after the request cycle at which the target UART is ready
    task automatic do_access(input logic w, input logic r, input logic [31:0] a, input int d);
        int         kind;
        int         c;
        logic [6:0] oh;
        logic [2:0] tgt;
        ref_decode(w, r, a, kind, oh);
        tgt = oh[6:4];
        @(negedge clk_i);
        we_i = w;
        re_i = r;
        addr_i = a;
        uart_ready_i = 3'($urandom_range(0, 7));
        #1;
        case (kind)
            0: tick(3'b000, 1'b0, 3'b000, 8'h00);
            1: tick(3'b000, 1'b0, {oh == 7'd8, oh == 7'd4, oh == 7'd1} & {3{w}},
                    r ? {1'b0, oh} : 8'h00);
            3: tick(3'b000, 1'b0, 3'b000, 8'h80);
            default: begin
                tick(tgt, 1'b1, 3'b000, 8'h00);
                c = (d <= T) ? d : T;
                for (int i = 1; i <= c; i++) begin
                    @(negedge clk_i);
                    uart_ready_i = (3'($urandom_range(0, 7)) & ~tgt) | ((i == d) ? tgt : 3'b000);
                    #1;
                    if (i < c) tick(3'b000, 1'b1, 3'b000, 8'h00);
                    else if (d <= T) tick(3'b000, 1'b0, 3'b000, r ? {1'b0, oh} : 8'h00);
                    else tick(3'b000, 1'b0, 3'b000, 8'h80);
                end
            end
        endcase
        @(negedge clk_i);
        we_i = 1'b0;
        re_i = 1'b0;
        addr_i = $urandom;
        uart_ready_i = 3'($urandom_range(0, 7));
        #1;
        tick(3'b000, 1'b0, 3'b000, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall_o, 0);
        check({tag, "_req"}, req_uart_o, 0);
        check({tag, "_we"}, {we_7seg_o, we_led_o, we_ram_o}, 0);
        check({tag, "_sel"}, sel_dispositivo_o, 0);
        check({tag, "_err"}, error_bus_o, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 9))
            0, 1: base = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
            2:    base = 32'h2000;
            3:    base = 32'h2004;
            4:    base = 32'h2008;
            5:    base = 32'h2010 + 32'($urandom_range(0, 15));
            6:    base = 32'h2020 + 32'($urandom_range(0, 15));
            7:    base = 32'h2030 + 32'($urandom_range(0, 15));
            8:    base = 32'h2000 + 32'($urandom_range(0, 32'h7F));
            default: base = $urandom;
        endcase
        if ($urandom_range(0, 3) != 0) base[1:0] = 2'b00;
        return base;
    endfunction

    initial begin
        logic w;
        logic r;
        checks = 0;
        errors = 0;
        rst_n_i = 1'b0;
        we_i = 1'b0;
        re_i = 1'b0;
        addr_i = 32'h0;
        uart_ready_i = 3'b000;
        repeat (2) @(negedge clk_i);
        we_i = 1'b1;
        addr_i = 32'h2004;
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        we_i = 1'b0;
        rst_n_i = 1'b1;
        exp_q = {8'h00};

        // directed cases
        do_access(1'b0, 1'b1, 32'h1004, 0);
        do_access(1'b1, 1'b0, 32'h2004, 0);
        do_access(1'b0, 1'b1, 32'h2020, 3);
        do_access(1'b1, 1'b0, 32'h2030, 100);
        do_access(1'b0, 1'b1, 32'h3000, 0);
        do_access(1'b0, 1'b1, 32'h1002, 0);
        do_access(1'b1, 1'b0, 32'h2000, 0);
        do_access(1'b1, 1'b1, 32'h1000, 0);
        do_access(1'b0, 1'b1, 32'h2014, T);
        do_access(1'b0, 1'b1, 32'h203C, T + 1);
        do_access(1'b1, 1'b0, 32'h1FFC, 0);
        do_access(1'b1, 1'b0, 32'h2008, 0);
        do_access(1'b0, 1'b1, 32'h2000, 0);

        // reset pulse in the middle of a UART wait
        @(negedge clk_i);
        we_i = 1'b0;
        re_i = 1'b1;
        addr_i = 32'h2010;
        uart_ready_i = 3'b000;
        #1;
        tick(3'b001, 1'b1, 3'b000, 8'h00);
        @(negedge clk_i);
        #1;
        tick(3'b000, 1'b1, 3'b000, 8'h00);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk_i);
        re_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        exp_q = {8'h00};
        @(negedge clk_i);
        uart_ready_i = 3'b001;
        #1;
        tick(3'b000, 1'b0, 3'b000, 8'h00);
        @(negedge clk_i);
        uart_ready_i = 3'b000;
        #1;
        tick(3'b000, 1'b0, 3'b000, 8'h00);

        // random transactions
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       begin w = 1'b0; r = 1'b0; end
                1:       begin w = 1'b1; r = 1'b1; end
                2, 3, 4: begin w = 1'b1; r = 1'b0; end
                default: begin w = 1'b0; r = 1'b1; end
            endcase
            do_access(w, r, rand_addr(), $urandom_range(1, T + 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
